deco_inst_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-register instruction decoder.
- Accepts raw instruction words over a valid/ready handshake and decodes class (arithmetic, logic, memory, branch), mode, register indices and a sign-extended immediate.
- Holds results in a 2-entry skid buffer so backpressure from the register-read stage never drops an instruction.
- Sits between instruction fetch and register read.

---
 rtl/deco_inst_pipe.sv | 213 +++++++++++++++++++++
 tb/tb_deco_inst_pipe.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/deco_inst_pipe.sv
// Pipelined instruction decoder with a 2-entry skid buffer toward register read.
// Optional per-class transfer counters when DECO_STATS_EN is defined.
module deco_inst_pipe #(
  parameter int IW   = 26,
  parameter int OPW  = 6,
  parameter int RW   = 5,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IW-1:0]   inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OPW-1:0]  opcode,
  output logic [1:0]      cls,
  output logic            is_imm,
  output logic [RW-1:0]   rd,
  output logic [RW-1:0]   rn,
  output logic [RW-1:0]   rm,
  output logic [XLEN-1:0] imm,
  output logic            uses_rm,
  output logic            writes_rd,
  output logic            illegal
`ifdef DECO_STATS_EN
  ,
  output logic [31:0]     stat_alu,
  output logic [31:0]     stat_logic,
  output logic [31:0]     stat_mem,
  output logic [31:0]     stat_branch,
  output logic [31:0]     stat_illegal
`endif
);

  localparam int SW = IW - OPW - 2*RW;
  localparam int LW = IW - OPW;

  typedef struct packed {
    logic [OPW-1:0]  opcode;
    logic [1:0]      cls;
    logic            is_imm;
    logic [RW-1:0]   rd;
    logic [RW-1:0]   rn;
    logic [RW-1:0]   rm;
    logic [XLEN-1:0] imm;
    logic            uses_rm;
    logic            writes_rd;
    logic            illegal;
  } bundle_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t  r_state;
  state_t  w_nxt;
  logic    r_in_ready;
  bundle_t r_head;
  bundle_t r_tail;
  bundle_t w_dec;
  logic    w_in;
  logic    w_out;
  logic    w_ld_head;
  logic    w_ld_tail;
  logic    w_shift;
  logic    w_clr_head;
  logic [XLEN-1:0] w_simm;
  logic [XLEN-1:0] w_limm;

  assign w_simm = {{(XLEN-SW){inst[SW-1]}}, inst[SW-1:0]};
  assign w_limm = {{(XLEN-LW){inst[LW-1]}}, inst[LW-1:0]};

  always_comb begin
    w_dec        = '0;
    w_dec.opcode = inst[IW-1 -: OPW];
    w_dec.cls    = inst[IW-1 -: 2];
    w_dec.is_imm = inst[IW-3];
    case (w_dec.cls)
      2'd0, 2'd1: begin
        w_dec.rd        = inst[IW-OPW-1 -: RW];
        w_dec.rn        = inst[IW-OPW-RW-1 -: RW];
        w_dec.writes_rd = 1'b1;
        if (!w_dec.is_imm) begin
          w_dec.rm      = inst[IW-OPW-2*RW-1 -: RW];
          w_dec.uses_rm = 1'b1;
        end else begin
          w_dec.imm     = w_simm;
        end
      end
      2'd2: begin
        if (w_dec.is_imm) begin
          w_dec.illegal   = 1'b1;
        end else begin
          w_dec.rd        = inst[IW-OPW-1 -: RW];
          w_dec.rn        = inst[IW-OPW-RW-1 -: RW];
          w_dec.imm       = w_simm;
          w_dec.writes_rd = ~inst[IW-4];
        end
      end
      2'd3: begin
        if (w_dec.is_imm) begin
          w_dec.imm = w_limm;
        end else begin
          w_dec.rd  = inst[IW-OPW-1 -: RW];
          w_dec.rn  = inst[IW-OPW-RW-1 -: RW];
          w_dec.imm = w_simm;
        end
      end
    endcase
  end

  assign w_in  = in_valid & r_in_ready;
  assign w_out = out_valid & out_ready;

  always_comb begin
    w_nxt      = r_state;
    w_ld_head  = 1'b0;
    w_ld_tail  = 1'b0;
    w_shift    = 1'b0;
    w_clr_head = 1'b0;
    if (flush) begin
      w_nxt      = EMPTY;
      w_clr_head = 1'b1;
    end else begin
      case (r_state)
        EMPTY: if (w_in) begin
          w_nxt     = ONE;
          w_ld_head = 1'b1;
        end
        ONE: begin
          if (w_in && w_out) begin
            w_ld_head = 1'b1;
          end else if (w_in) begin
            w_nxt     = TWO;
            w_ld_tail = 1'b1;
          end else if (w_out) begin
            w_nxt      = EMPTY;
            w_clr_head = 1'b1;
          end
        end
        TWO: if (w_out) begin
          w_nxt   = ONE;
          w_shift = 1'b1;
        end
        default: w_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      r_state    <= w_nxt;
      r_in_ready <= (w_nxt != TWO);
      if (w_clr_head)     r_head <= '0;
      else if (w_ld_head) r_head <= w_dec;
      else if (w_shift)   r_head <= r_tail;
      if (w_ld_tail)      r_tail <= w_dec;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != EMPTY);
  assign opcode    = r_head.opcode;
  assign cls       = r_head.cls;
  assign is_imm    = r_head.is_imm;
  assign rd        = r_head.rd;
  assign rn        = r_head.rn;
  assign rm        = r_head.rm;
  assign imm       = r_head.imm;
  assign uses_rm   = r_head.uses_rm;
  assign writes_rd = r_head.writes_rd;
  assign illegal   = r_head.illegal;

`ifdef DECO_STATS_EN
  logic [31:0] r_st_alu;
  logic [31:0] r_st_logic;
  logic [31:0] r_st_mem;
  logic [31:0] r_st_branch;
  logic [31:0] r_st_ill;
  logic        w_cnt;

  // a transfer in a flush cycle is discarded, so it is not counted
  assign w_cnt = w_out & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st_alu    <= '0;
      r_st_logic  <= '0;
      r_st_mem    <= '0;
      r_st_branch <= '0;
      r_st_ill    <= '0;
    end else if (w_cnt) begin
      if (r_head.illegal)          r_st_ill    <= r_st_ill + 32'd1;
      else if (r_head.cls == 2'd0) r_st_alu    <= r_st_alu + 32'd1;
      else if (r_head.cls == 2'd1) r_st_logic  <= r_st_logic + 32'd1;
      else if (r_head.cls == 2'd2) r_st_mem    <= r_st_mem + 32'd1;
      else                         r_st_branch <= r_st_branch + 32'd1;
    end
  end

  assign stat_alu     = r_st_alu;
  assign stat_logic   = r_st_logic;
  assign stat_mem     = r_st_mem;
  assign stat_branch  = r_st_branch;
  assign stat_illegal = r_st_ill;
`endif

endmodule

// File: tb/tb_deco_inst_pipe.sv
// Scoreboard bench for deco_inst_pipe: directed vectors, queue-based monitor.
// Covers decode classes, backpressure, flush, async reset and optional stats.
module tb_deco_inst_pipe;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [1:0]  cls;
    logic        is_imm;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [31:0] imm;
    logic        uses_rm;
    logic        writes_rd;
    logic        illegal;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [25:0] inst;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  opcode;
  logic [1:0]  cls;
  logic        is_imm;
  logic [4:0]  rd;
  logic [4:0]  rn;
  logic [4:0]  rm;
  logic [31:0] imm;
  logic        uses_rm;
  logic        writes_rd;
  logic        illegal;
`ifdef DECO_STATS_EN
  logic [31:0] stat_alu;
  logic [31:0] stat_logic;
  logic [31:0] stat_mem;
  logic [31:0] stat_branch;
  logic [31:0] stat_illegal;
`endif

  int   n_chk;
  int   n_fail;
  exp_t q[$];
  logic [25:0] vi[9];
  exp_t        ve[9];
  exp_t        act;

  deco_inst_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inst      (inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .opcode    (opcode),
    .cls       (cls),
    .is_imm    (is_imm),
    .rd        (rd),
    .rn        (rn),
    .rm        (rm),
    .imm       (imm),
    .uses_rm   (uses_rm),
    .writes_rd (writes_rd),
    .illegal   (illegal)
`ifdef DECO_STATS_EN
    ,
    .stat_alu     (stat_alu),
    .stat_logic   (stat_logic),
    .stat_mem     (stat_mem),
    .stat_branch  (stat_branch),
    .stat_illegal (stat_illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign act = {opcode, cls, is_imm, rd, rn, rm, imm,
                uses_rm, writes_rd, illegal};

  function automatic exp_t mk(input logic [5:0] op, input logic [1:0] c,
                              input logic ii, input logic [4:0] d,
                              input logic [4:0] n, input logic [4:0] m,
                              input logic [31:0] im, input logic u,
                              input logic w, input logic il);
    exp_t e;
    e = {op, c, ii, d, n, m, im, u, w, il};
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  // monitor: every output transfer must match the oldest expected bundle
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got %h expected none", act);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (act !== e) begin
          n_fail++;
          $display("FAIL bundle: got %h expected %h", act, e);
        end
      end
    end
  end

  task automatic send(input logic [25:0] w, input exp_t e);
    int t;
    t = 0;
    in_valid = 1'b1;
    inst     = w;
    while (!in_ready && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
    end else begin
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d left expected 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    vi[0] = {6'h00, 5'd3, 5'd4, 10'h0A0};
    ve[0] = mk(6'h00, 2'd0, 1'b0, 5'd3, 5'd4, 5'd5, 32'h0, 1'b1, 1'b1, 1'b0);
    vi[1] = {6'h18, 5'd7, 5'd2, 10'h3FF};
    ve[1] = mk(6'h18, 2'd1, 1'b1, 5'd7, 5'd2, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
    vi[2] = {6'h18, 5'd1, 5'd1, 10'h1FF};
    ve[2] = mk(6'h18, 2'd1, 1'b1, 5'd1, 5'd1, 5'd0, 32'h000001FF, 1'b0, 1'b1, 1'b0);
    vi[3] = {6'h38, 20'h80000};
    ve[3] = mk(6'h38, 2'd3, 1'b1, 5'd0, 5'd0, 5'd0, 32'hFFF80000, 1'b0, 1'b0, 1'b0);
    vi[4] = {6'h28, 5'd9, 5'd9, 10'h3FF};
    ve[4] = mk(6'h28, 2'd2, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    vi[5] = {6'h20, 5'd6, 5'd8, 10'h200};
    ve[5] = mk(6'h20, 2'd2, 1'b0, 5'd6, 5'd8, 5'd0, 32'hFFFFFE00, 1'b0, 1'b1, 1'b0);
    vi[6] = {6'h24, 5'd2, 5'd3, 10'h005};
    ve[6] = mk(6'h24, 2'd2, 1'b0, 5'd2, 5'd3, 5'd0, 32'h00000005, 1'b0, 1'b0, 1'b0);
    vi[7] = {6'h30, 5'd1, 5'd2, 10'h3F0};
    ve[7] = mk(6'h30, 2'd3, 1'b0, 5'd1, 5'd2, 5'd0, 32'hFFFFFFF0, 1'b0, 1'b0, 1'b0);
    vi[8] = {6'h07, 5'd31, 5'd0, 10'h3E1};
    ve[8] = mk(6'h07, 2'd0, 1'b0, 5'd31, 5'd0, 5'd31, 32'h0, 1'b1, 1'b1, 1'b0);

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; inst = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_bundle", 64'(act), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // decode table at full throughput, latency check on the first word
    out_ready = 1'b1;
    send(vi[0], ve[0]);
    chk("latency_valid", 64'(out_valid), 64'd1);
    for (int i = 1; i < 9; i++) send(vi[i], ve[i]);
    drain();

    // backpressure: A, B fill the buffer, C waits
    out_ready = 1'b0;
    send(vi[1], ve[1]);
    send(vi[3], ve[3]);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    chk("bp_head", 64'(act), 64'(ve[1]));
    out_ready = 1'b1;
    send(vi[5], ve[5]);
    drain();

    // flush in TWO with an offered word
    out_ready = 1'b0;
    send(vi[6], ve[6]);
    send(vi[7], ve[7]);
    flush = 1'b1; in_valid = 1'b1; inst = vi[2];
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    q.delete();
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    send(vi[0], ve[0]);
    send(vi[8], ve[8]);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_bundle", 64'(act), 64'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

`ifdef DECO_STATS_EN
    out_ready = 1'b1;
    send(vi[0], ve[0]);
    send(vi[8], ve[8]);
    send(vi[0], ve[0]);
    send(vi[4], ve[4]);
    drain();
    chk("stat_alu", 64'(stat_alu), 64'd3);
    chk("stat_illegal", 64'(stat_illegal), 64'd1);
    chk("stat_mem", 64'(stat_mem), 64'd0);
    chk("stat_logic", 64'(stat_logic), 64'd0);
    rst = 1'b1;
    #1;
    chk("stat_alu_rst", 64'(stat_alu), 64'd0);
    chk("stat_ill_rst", 64'(stat_illegal), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
`endif

    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
